// File: rtl/dct_pkg.sv
// dct_pkg: constants, coefficient type, row-order map and sequencer states
// shared by dct_row_1d and its dot-product pipeline dct_row_mac.
package dct_pkg;

    localparam int COEF_W = 12;
    localparam int K_W    = 13;

    // Q12 of 0.5*cos(m*pi/16), m = 1..7
    localparam logic signed [K_W-1:0] K1 = 13'sd2009;
    localparam logic signed [K_W-1:0] K2 = 13'sd1892;
    localparam logic signed [K_W-1:0] K3 = 13'sd1703;
    localparam logic signed [K_W-1:0] K4 = 13'sd1448;
    localparam logic signed [K_W-1:0] K5 = 13'sd1138;
    localparam logic signed [K_W-1:0] K6 = 13'sd784;
    localparam logic signed [K_W-1:0] K7 = 13'sd400;

    typedef logic signed [COEF_W-1:0] coef_t;

    // Entry n (3 bits each, LSB first) is the block row of the n-th completed row.
    localparam logic [23:0] ROW_MAP = {3'd4, 3'd3, 3'd5, 3'd2, 3'd6, 3'd1, 3'd7, 3'd0};

    typedef enum logic {SEQ_IDLE, SEQ_EMIT} seq_state_e;

    function automatic logic [2:0] row_map(input logic [2:0] rc);
        return ROW_MAP[3*int'(rc) +: 3];
    endfunction

endpackage

// File: rtl/dct_row_mac.sv
// dct_row_mac: 4-term signed constant dot product; in_k picks the constant and
// sign set of one DCT coefficient. Stage 1 registers products, stage 2 the rounded sum.
module dct_row_mac
    import dct_pkg::*;
#(
    parameter int TERM_W = 10,
    parameter int TAG_W  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [2:0]        in_k,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [TERM_W-1:0] in_t0,
    input  logic [TERM_W-1:0] in_t1,
    input  logic [TERM_W-1:0] in_t2,
    input  logic [TERM_W-1:0] in_t3,
    output logic              out_valid,
    output logic [TAG_W-1:0]  out_tag,
    output logic [COEF_W-1:0] out_data
);

    localparam int P_W   = K_W + TERM_W;
    localparam int ACC_W = P_W + 2;

    logic signed [K_W-1:0]    kc [4];
    logic signed [TERM_W-1:0] t [4];
    logic signed [P_W-1:0]    prod_d [4];
    logic signed [P_W-1:0]    prod_q [4];
    logic signed [ACC_W-1:0]  sum;
    logic                     v1_d, v1_q, valid_d, valid_q;
    logic [TAG_W-1:0]         tag1_d, tag1_q, tag_d, tag_q;
    coef_t                    data_d, data_q;

    always_comb begin
        t[0] = in_t0;
        t[1] = in_t1;
        t[2] = in_t2;
        t[3] = in_t3;
        kc = '{K4, K4, K4, K4};
        // Even k weight the sums a0..a3, odd k the differences b0..b3.
        case (in_k)
            3'd0:    kc = '{K4,  K4,  K4,  K4};
            3'd1:    kc = '{K1,  K3,  K5,  K7};
            3'd2:    kc = '{K2,  K6, -K6, -K2};
            3'd3:    kc = '{K3, -K7, -K1, -K5};
            3'd4:    kc = '{K4, -K4, -K4,  K4};
            3'd5:    kc = '{K5, -K1,  K7,  K3};
            3'd6:    kc = '{K6, -K2,  K2, -K6};
            default: kc = '{K7, -K5,  K3, -K1};
        endcase
        for (int j = 0; j < 4; j++) begin
            prod_d[j] = P_W'(kc[j]) * P_W'(t[j]);
        end
        v1_d   = in_valid;
        tag1_d = in_tag;

        sum     = ACC_W'(prod_q[0]) + ACC_W'(prod_q[1]) + ACC_W'(prod_q[2]) + ACC_W'(prod_q[3]);
        data_d  = coef_t'((sum + ACC_W'(2048)) >>> 12);
        valid_d = v1_q;
        tag_d   = tag1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < 4; j++) prod_q[j] <= '0;
            v1_q    <= 1'b0;
            tag1_q  <= '0;
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            prod_q  <= prod_d;
            v1_q    <= v1_d;
            tag1_q  <= tag1_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_tag   = tag_q;
    assign out_data  = data_q;

endmodule

// File: rtl/dct_row_1d.sv
// dct_row_1d: 8-point row DCT-II fed in butterfly pair order, emitting Y0..Y7 in
// natural order with row/index tags. Define DCT_LEVEL_SHIFT_EN to subtract 128 from samples.
module dct_row_1d
    import dct_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic [2:0]       out_idx,
    output logic [2:0]       out_row,
    output logic             out_last
);

    localparam int S_W = IN_W + 1;
    localparam int A_W = IN_W + 2;

    logic [2:0]            pos_q, pos_d, rc_q, rc_d;
    logic signed [S_W-1:0] s_cur, s_hold_q, s_hold_d;
    logic signed [A_W-1:0] cap_a_q [4], cap_a_d [4], cap_b_q [4], cap_b_d [4];
    logic signed [A_W-1:0] hold_a_q [4], hold_a_d [4], hold_b_q [4], hold_b_d [4];
    logic                  load;

    seq_state_e            state_q, state_d;
    logic [2:0]            k_q, k_d, row_q, row_d;
    logic                  blk_end_q, blk_end_d;

    logic [A_W-1:0]        term [4];
    logic                  mac_valid;
    logic [6:0]            mac_tag;
    logic [COEF_W-1:0]     mac_data;

    always_comb begin
`ifdef DCT_LEVEL_SHIFT_EN
        s_cur = {1'b0, in_data} - S_W'(1 << (IN_W - 1));
`else
        s_cur = {1'b0, in_data};
`endif
    end

    assign load = in_valid && (pos_q == 3'd7);

    always_comb begin
        pos_d    = pos_q;
        s_hold_d = s_hold_q;
        cap_a_d  = cap_a_q;
        cap_b_d  = cap_b_q;
        hold_a_d = hold_a_q;
        hold_b_d = hold_b_q;
        rc_d     = rc_q;
        if (in_valid) begin
            pos_d = pos_q + 3'd1;
            if (!pos_q[0]) begin
                s_hold_d = s_cur;
            end else begin
                cap_a_d[pos_q[2:1]] = A_W'(s_hold_q) + A_W'(s_cur);
                cap_b_d[pos_q[2:1]] = A_W'(s_hold_q) - A_W'(s_cur);
            end
        end
        // The hold bank takes the pair being completed this edge (a3/b3) as well.
        if (load) begin
            hold_a_d = cap_a_d;
            hold_b_d = cap_b_d;
            rc_d     = rc_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q    <= '0;
            rc_q     <= '0;
            s_hold_q <= '0;
            for (int j = 0; j < 4; j++) begin
                cap_a_q[j]  <= '0;
                cap_b_q[j]  <= '0;
                hold_a_q[j] <= '0;
                hold_b_q[j] <= '0;
            end
        end else begin
            pos_q    <= pos_d;
            rc_q     <= rc_d;
            s_hold_q <= s_hold_d;
            cap_a_q  <= cap_a_d;
            cap_b_q  <= cap_b_d;
            hold_a_q <= hold_a_d;
            hold_b_q <= hold_b_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        row_d     = row_q;
        blk_end_d = blk_end_q;
        case (state_q)
            SEQ_IDLE: begin
                if (load) begin
                    state_d = SEQ_EMIT;
                    k_d     = 3'd0;
                end
            end
            default: begin
                if (k_q == 3'd7) begin
                    k_d = 3'd0;
                    if (!load) state_d = SEQ_IDLE;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
        endcase
        if (load) begin
            row_d     = row_map(rc_q);
            blk_end_d = (rc_q == 3'd7);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SEQ_IDLE;
            k_q       <= '0;
            row_q     <= '0;
            blk_end_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            row_q     <= row_d;
            blk_end_q <= blk_end_d;
        end
    end

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            term[j] = k_q[0] ? hold_b_q[j] : hold_a_q[j];
        end
    end

    dct_row_mac #(
        .TERM_W (A_W),
        .TAG_W  (7)
    ) u_mac (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (state_q == SEQ_EMIT),
        .in_k      (k_q),
        .in_tag    ({blk_end_q && (k_q == 3'd7), row_q, k_q}),
        .in_t0     (term[0]),
        .in_t1     (term[1]),
        .in_t2     (term[2]),
        .in_t3     (term[3]),
        .out_valid (mac_valid),
        .out_tag   (mac_tag),
        .out_data  (mac_data)
    );

    assign out_valid = mac_valid;
    assign out_last  = mac_tag[6];
    assign out_row   = mac_tag[5:3];
    assign out_idx   = mac_tag[2:0];
    assign out_data  = OUT_W'($signed(mac_data));

endmodule

// File: tb/tb_dct_row_1d.sv
// tb_dct_row_1d: scoreboard bench for dct_row_1d; expected coefficients come
// from a direct evaluation of the DCT formulas on each driven row.
`timescale 1ns/1ps
module tb_dct_row_1d;

    localparam int IN_W  = 8;
    localparam int OUT_W = 12;
    localparam int EW    = 1 + 3 + 3 + OUT_W;
    localparam int NONE  = -9999;

`ifdef DCT_LEVEL_SHIFT_EN
    localparam int Y0_128 = 0;
    localparam int Y0_255 = 359;
    localparam int Y0_IMP = 45;
`else
    localparam int Y0_128 = 362;
    localparam int Y0_255 = 721;
    localparam int Y0_IMP = 407;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [IN_W-1:0]  in_data = '0;
    logic             out_valid;
    logic [OUT_W-1:0] out_data;
    logic [2:0]       out_idx, out_row;
    logic             out_last;

    dct_row_1d #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_row   (out_row),
        .out_last  (out_last)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic             last;
        logic [2:0]       row;
        logic [2:0]       idx;
        logic [OUT_W-1:0] data;
    } ent_t;

    logic [EW-1:0] exp_q[$];
    ent_t          obs_q[$];
    int            obs_cyc_q[$];
    int            acc_q[$];
    int            row_px[8];
    int            mdl_rc = 0;
    int            row_map[8] = '{0, 7, 1, 6, 2, 5, 3, 4};

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            obs_q.push_back({out_last, out_row, out_idx, out_data});
            obs_cyc_q.push_back(cyc);
        end
    end

    // ---------------- reference model ----------------
    function automatic int model_y(input int k);
        int s[8];
        int a[4];
        int b[4];
        int sum;
        for (int i = 0; i < 8; i++) begin
`ifdef DCT_LEVEL_SHIFT_EN
            s[i] = row_px[i] - 128;
`else
            s[i] = row_px[i];
`endif
        end
        for (int i = 0; i < 4; i++) begin
            a[i] = s[i] + s[7-i];
            b[i] = s[i] - s[7-i];
        end
        case (k)
            0: sum = 1448 * (a[0] + a[1] + a[2] + a[3]);
            1: sum = 2009 * b[0] + 1703 * b[1] + 1138 * b[2] + 400 * b[3];
            2: sum = 1892 * a[0] + 784 * a[1] - 784 * a[2] - 1892 * a[3];
            3: sum = 1703 * b[0] - 400 * b[1] - 2009 * b[2] - 1138 * b[3];
            4: sum = 1448 * (a[0] - a[1] - a[2] + a[3]);
            5: sum = 1138 * b[0] - 2009 * b[1] + 400 * b[2] + 1703 * b[3];
            6: sum = 784 * a[0] - 1892 * a[1] + 1892 * a[2] - 784 * a[3];
            default: sum = 400 * b[0] - 1138 * b[1] + 1703 * b[2] - 2009 * b[3];
        endcase
        return (sum + 2048) >>> 12;
    endfunction

    // Known answers for the fixed patterns; NONE means no fixed value is asserted.
    function automatic int known_y(input int pat, input int k);
        case (pat)
            0: return (k == 0) ? Y0_128 : 0;
            1: return (k == 0) ? Y0_255 : 0;
            default: return (k == 0) ? Y0_IMP : (k == 1) ? 62 : (k == 2) ? 59 : NONE;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_row(input int gap_max);
        int ord[8] = '{0, 7, 1, 6, 2, 5, 3, 4};
        int g;
        for (int n = 0; n < 8; n++) begin
            g = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
            in_valid = 1'b0;
            repeat (g) begin @(posedge clk); #1; end
            in_valid = 1'b1;
            in_data  = IN_W'(row_px[ord[n]]);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        acc_q.push_back(cyc);
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back({1'(k == 7 && mdl_rc == 7), 3'(row_map[mdl_rc]), 3'(k), OUT_W'(model_y(k))});
        end
        mdl_rc = (mdl_rc + 1) % 8;
    endtask

    task automatic random_row();
        for (int j = 0; j < 8; j++) row_px[j] = $urandom_range(255, 0);
    endtask

    task automatic wait_obs(input int n);
        for (int t = 0; t < 400 && obs_q.size() < n; t++) begin @(posedge clk); #1; end
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic flush();
        exp_q.delete();
        obs_q.delete();
        obs_cyc_q.delete();
        acc_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", out_data); end
        checks++; if (out_idx !== 3'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", out_idx); end
        checks++; if (out_row !== 3'd0) begin failures++; $display("FAIL reset_row got=%0d exp=0", out_row); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", out_last); end
        rst_n = 1'b1;
        mdl_rc = 0;
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_known_row(input int pat);
        ent_t          ob;
        logic [EW-1:0] ex;
        int            oc, acc, i, kv;
        for (int j = 0; j < 8; j++) row_px[j] = (pat == 1) ? 255 : 128;
        if (pat == 2) row_px[0] = 255;
        drive_row(0);
        wait_obs(8);
        checks++; if (obs_q.size() != 8) begin failures++; $display("FAIL known%0d_count got=%0d exp=8", pat, obs_q.size()); end
        acc = acc_q.pop_front();
        i = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ob = obs_q.pop_front(); ex = exp_q.pop_front(); oc = obs_cyc_q.pop_front();
            checks++; if (ob !== ex) begin failures++; $display("FAIL known%0d_sb[%0d] got=%h exp=%h", pat, i, ob, ex); end
            checks++; if (oc != acc + 2 + i) begin failures++; $display("FAIL known%0d_cycle[%0d] got=%0d exp=%0d", pat, i, oc, acc + 2 + i); end
            kv = known_y(pat, i);
            if (kv != NONE) begin
                checks++;
                if (ob.data !== OUT_W'(kv)) begin failures++; $display("FAIL known%0d_y%0d got=%0d exp=%0d", pat, i, $signed(ob.data), kv); end
            end
            i++;
        end
        flush();
    endtask

    task automatic test_gaps();
        ent_t          ob;
        logic [EW-1:0] ex;
        int            oc, acc, i;
        logic [OUT_W-1:0] ref_y[8];
        for (int r = 0; r < 3; r++) begin
            random_row();
            for (int p = 0; p < 2; p++) begin
                drive_row(p == 0 ? 0 : 4);
                wait_obs(8);
                checks++; if (obs_q.size() != 8) begin failures++; $display("FAIL gaps_count r%0d p%0d got=%0d exp=8", r, p, obs_q.size()); end
                acc = acc_q.pop_front();
                i = 0;
                while (obs_q.size() > 0 && exp_q.size() > 0) begin
                    ob = obs_q.pop_front(); ex = exp_q.pop_front(); oc = obs_cyc_q.pop_front();
                    checks++; if (ob !== ex) begin failures++; $display("FAIL gaps_sb r%0d p%0d [%0d] got=%h exp=%h", r, p, i, ob, ex); end
                    checks++; if (oc != acc + 2 + i) begin failures++; $display("FAIL gaps_latency r%0d p%0d [%0d] got=%0d exp=%0d", r, p, i, oc, acc + 2 + i); end
                    if (p == 0) ref_y[i] = ob.data;
                    else begin
                        checks++;
                        if (ob.data !== ref_y[i]) begin failures++; $display("FAIL gaps_vs_nogap r%0d [%0d] got=%h exp=%h", r, i, ob.data, ref_y[i]); end
                    end
                    i++;
                end
                flush();
            end
        end
    endtask

    task automatic test_reset_mid_row();
        ent_t          ob;
        logic [EW-1:0] ex;
        int            i;
        for (int n = 0; n < 5; n++) begin
            in_valid = 1'b1;
            in_data  = IN_W'($urandom_range(255, 0));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n  = 1'b1;
        mdl_rc = 0;
        repeat (20) begin @(posedge clk); #1; end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL midrst_no_output got=%0d exp=0", obs_q.size()); end
        flush();
        random_row();
        drive_row(2);
        wait_obs(8);
        checks++; if (obs_q.size() != 8) begin failures++; $display("FAIL midrst_count got=%0d exp=8", obs_q.size()); end
        i = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ob = obs_q.pop_front(); ex = exp_q.pop_front(); void'(obs_cyc_q.pop_front());
            checks++; if (ob !== ex) begin failures++; $display("FAIL midrst_sb[%0d] got=%h exp=%h", i, ob, ex); end
            checks++; if (ob.row !== 3'd0) begin failures++; $display("FAIL midrst_row[%0d] got=%0d exp=0", i, ob.row); end
            i++;
        end
        flush();
    endtask

    task automatic test_back_to_back();
        ent_t          ob;
        logic [EW-1:0] ex;
        int            oc, acc, i, n_last;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mdl_rc = 0;
        flush();
        for (int r = 0; r < 8; r++) begin
            random_row();
            drive_row(0);
        end
        wait_obs(64);
        checks++; if (obs_q.size() != 64) begin failures++; $display("FAIL b2b_count got=%0d exp=64", obs_q.size()); end
        i = 0; n_last = 0; acc = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ob = obs_q.pop_front(); ex = exp_q.pop_front(); oc = obs_cyc_q.pop_front();
            if (i % 8 == 0) acc = acc_q.pop_front();
            checks++; if (ob !== ex) begin failures++; $display("FAIL b2b_sb[%0d] got=%h exp=%h", i, ob, ex); end
            checks++; if (oc != acc + 2 + (i % 8)) begin failures++; $display("FAIL b2b_cycle[%0d] got=%0d exp=%0d", i, oc, acc + 2 + (i % 8)); end
            checks++; if (ob.row !== 3'(row_map[i / 8])) begin failures++; $display("FAIL b2b_row[%0d] got=%0d exp=%0d", i, ob.row, row_map[i / 8]); end
            checks++; if (ob.last !== (i == 63)) begin failures++; $display("FAIL b2b_last[%0d] got=%b exp=%b", i, ob.last, i == 63); end
            if (ob.last) n_last++;
            i++;
        end
        checks++; if (n_last != 1) begin failures++; $display("FAIL b2b_last_count got=%0d exp=1", n_last); end
        flush();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_known_row(0);
        test_known_row(1);
        test_known_row(2);
        test_gaps();
        test_reset_mid_row();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
